// File: rtl/key_loader_pkg.sv
// Shared types and width helpers for the serial key loader.
package key_loader_pkg;

  typedef enum logic [1:0] {
    RECV    = 2'd0,
    CHECK   = 2'd1,
    LOADED  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // Bits needed to encode values 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_frame_rx.sv
// Frame receiver: shift register, saturating beat counter and running parity.
module key_frame_rx
  import key_loader_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 beat,
  input  logic                 bit_in,
  input  logic                 last,
  output logic                 frame_done,
  output logic                 len_ok,
  output logic                 par_ok,
  output logic [KEY_WIDTH-1:0] data
);

  localparam int unsigned FW = KEY_WIDTH + 1;
  localparam int unsigned BW = cnt_width(KEY_WIDTH + 3);

  logic [FW-1:0] sh;
  logic [BW-1:0] cnt;
  logic          par;

  // Beats enter at the top and shift down, so beat 0 ends at bit 0 after a full frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
      par <= 1'b0;
    end else if (clr) begin
      sh  <= '0;
      cnt <= '0;
      par <= 1'b0;
    end else if (beat) begin
      if (cnt < BW'(FW)) begin
        sh  <= {bit_in, sh[FW-1:1]};
        par <= par ^ bit_in;
      end
      if (cnt != BW'(FW + 1)) begin
        cnt <= cnt + BW'(1);
      end
    end
  end

  assign frame_done = beat & last;
  assign len_ok     = (cnt == BW'(FW));
  assign par_ok     = ~par;
  assign data       = sh[KEY_WIDTH-1:0];

endmodule

// File: rtl/key_loader.sv
// Key provisioning front end: validates a serial key frame and drives the locked core's key bus.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int unsigned          KEY_WIDTH = 8,
  parameter logic [KEY_WIDTH-1:0] DECOY_KEY = '0,
  parameter int unsigned          MAX_FAIL  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_data,
  input  logic                 s_last,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 load_err,
  output logic                 locked_out
);

  localparam int unsigned FFW = cnt_width(MAX_FAIL + 1);

  state_t               state_q, state_n;
  logic [FFW-1:0]       fail_q, fail_n, fail_inc;
  logic [KEY_WIDTH-1:0] key_n;
  logic                 key_valid_n, load_err_n, locked_n;
  logic                 rx_clr, beat;
  logic                 frame_done, len_ok, par_ok;
  logic [KEY_WIDTH-1:0] rx_key;

  assign beat     = s_valid & s_ready;
  assign fail_inc = fail_q + FFW'(1);

  key_frame_rx #(
    .KEY_WIDTH (KEY_WIDTH)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .clr        (rx_clr),
    .beat       (beat),
    .bit_in     (s_data),
    .last       (s_last),
    .frame_done (frame_done),
    .len_ok     (len_ok),
    .par_ok     (par_ok),
    .data       (rx_key)
  );

  // State, fail counter and all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RECV;
      fail_q     <= '0;
      s_ready    <= 1'b1;
      key_out    <= DECOY_KEY;
      key_valid  <= 1'b0;
      load_err   <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state_q    <= state_n;
      fail_q     <= fail_n;
      s_ready    <= (state_n == RECV);
      key_out    <= key_n;
      key_valid  <= key_valid_n;
      load_err   <= load_err_n;
      locked_out <= locked_n;
    end
  end

  // Next-state logic: the frame is judged in CHECK, after its last beat has been registered.
  always_comb begin
    state_n     = state_q;
    fail_n      = fail_q;
    key_n       = key_out;
    key_valid_n = key_valid;
    load_err_n  = 1'b0;
    locked_n    = locked_out;
    rx_clr      = 1'b0;
    unique case (state_q)
      RECV: begin
        if (frame_done) begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        rx_clr = 1'b1;
        if (len_ok && par_ok) begin
          state_n     = LOADED;
          key_n       = rx_key;
          key_valid_n = 1'b1;
          fail_n      = '0;
        end else begin
          load_err_n = 1'b1;
          fail_n     = fail_inc;
          if (fail_inc == FFW'(MAX_FAIL)) begin
            state_n  = LOCKOUT;
            locked_n = 1'b1;
          end else begin
            state_n = RECV;
          end
        end
      end
      LOADED: begin
        state_n = LOADED;
      end
      LOCKOUT: begin
        state_n = LOCKOUT;
      end
      default: begin
        state_n = RECV;
      end
    endcase
  end

endmodule

// File: tb/tb_key_loader.sv
// Bench for key_loader: frame-level reference model plus directed and random frames.
module tb_key_loader;

  localparam int unsigned W  = 8;
  localparam int unsigned MF = 3;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_data  = 1'b0;
  logic         s_last  = 1'b0;
  logic         s_ready;
  logic [W-1:0] key_out;
  logic         key_valid;
  logic         load_err;
  logic         locked_out;

  key_loader #(
    .KEY_WIDTH (W),
    .DECOY_KEY ('0),
    .MAX_FAIL  (MF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .load_err   (load_err),
    .locked_out (locked_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects accepted bits per frame and judges the whole frame at its end.
  bit           q[$];
  bit           m_ready = 1'b1, m_valid = 1'b0, m_err = 1'b0, m_locked = 1'b0;
  bit           pend = 1'b0, pend_good = 1'b0, model_live = 1'b0, xacc;
  logic [W-1:0] m_key = '0, pend_key = '0;
  int           m_fails = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ready = 1'b1; m_valid = 1'b0; m_err = 1'b0; m_locked = 1'b0;
      pend = 1'b0; m_key = '0; m_fails = 0; model_live = 1'b1;
    end else if (pend) begin
      pend = 1'b0;
      if (pend_good) begin
        m_key = pend_key; m_valid = 1'b1; m_fails = 0;
      end else begin
        m_err = 1'b1;
        m_fails++;
        if (m_fails == int'(MF)) m_locked = 1'b1;
        else m_ready = 1'b1;
      end
    end else begin
      m_err = 1'b0;
      if (s_valid && m_ready) begin
        q.push_back(s_data);
        if (s_last) begin
          xacc = 1'b0;
          foreach (q[i]) xacc ^= q[i];
          pend_good = (q.size() == int'(W + 1)) && !xacc;
          for (int i = 0; i < int'(W); i++) pend_key[i] = (i < q.size()) ? q[i] : 1'b0;
          pend = 1'b1;
          m_ready = 1'b0;
          q.delete();
        end
      end
    end
  end

  // Every cycle outside reset, the DUT outputs must match the model.
  always @(negedge clk) begin
    if (model_live && !rst) begin
      check("s_ready",    32'(s_ready),    32'(m_ready));
      check("key_out",    32'(key_out),    32'(m_key));
      check("key_valid",  32'(key_valid),  32'(m_valid));
      check("load_err",   32'(load_err),   32'(m_err));
      check("locked_out", 32'(locked_out), 32'(m_locked));
      if (load_err) err_pulses++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives n beats of bits (bit i first); gap is the bubble percentage.
  task automatic drive_frame(input logic [15:0] bits, input int n, input int gap,
                             input bit blocked_ok, input bit set_last);
    for (int i = 0; i < n; i++) begin
      int  waited = 0;
      bit  acc = 1'b0;
      while (!acc) begin
        @(negedge clk); #1;
        s_valid = ($urandom_range(99) >= 32'(gap));
        s_data  = bits[i];
        s_last  = set_last && (i == n - 1);
        acc     = s_valid && s_ready;
        waited++;
        if (!acc && waited > 40) begin
          if (!blocked_ok) check("beat_timeout", 32'd0, 32'd1);
          s_valid = 1'b0; s_last = 1'b0;
          return;
        end
      end
    end
    @(negedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  function automatic logic [15:0] mk(input logic [7:0] k, input bit flip);
    return 16'({(^k) ^ flip, k});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [15:0] bits;
    int len;

    do_reset();
    wait_cycles(1);
    check("rst_ready",  32'(s_ready),    32'd1);
    check("rst_key",    32'(key_out),    32'h00);
    check("rst_valid",  32'(key_valid),  32'd0);
    check("rst_err",    32'(load_err),   32'd0);
    check("rst_locked", 32'(locked_out), 32'd0);

    // Good 0xA5 frame.
    drive_frame(mk(8'hA5, 1'b0), 9, 0, 1'b0, 1'b1);
    wait_cycles(2);
    check("a5_key",   32'(key_out),   32'hA5);
    check("a5_valid", 32'(key_valid), 32'd1);
    check("a5_ready", 32'(s_ready),   32'd0);

    // Bad parity, then a good 0x3C frame.
    do_reset();
    e0 = err_pulses;
    drive_frame(mk(8'hA5, 1'b1), 9, 0, 1'b0, 1'b1);
    wait_cycles(3);
    check("badpar_pulses", 32'(err_pulses - e0), 32'd1);
    check("badpar_key",    32'(key_out),         32'h00);
    check("badpar_ready",  32'(s_ready),         32'd1);
    drive_frame(mk(8'h3C, 1'b0), 9, 0, 1'b0, 1'b1);
    wait_cycles(2);
    check("3c_key", 32'(key_out), 32'h3C);

    // Short and long frames.
    do_reset();
    e0 = err_pulses;
    drive_frame(16'h0015, 5, 0, 1'b0, 1'b1);
    wait_cycles(2);
    drive_frame(16'h05A5, 11, 0, 1'b0, 1'b1);
    wait_cycles(2);
    check("shortlong_pulses", 32'(err_pulses - e0), 32'd2);
    check("shortlong_key",    32'(key_out),         32'h00);

    // Lockout after three bad frames; later good frame ignored.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_frame(mk(8'h5A, 1'b1), 9, 0, 1'b0, 1'b1);
      wait_cycles(2);
    end
    check("lock_locked", 32'(locked_out), 32'd1);
    check("lock_ready",  32'(s_ready),    32'd0);
    drive_frame(mk(8'hA5, 1'b0), 9, 0, 1'b1, 1'b1);
    check("lock_valid", 32'(key_valid), 32'd0);
    check("lock_key",   32'(key_out),   32'h00);
    do_reset();
    wait_cycles(1);
    check("unlock_locked", 32'(locked_out), 32'd0);
    check("unlock_ready",  32'(s_ready),    32'd1);

    // Bubbles inside a good frame.
    drive_frame(mk(8'h3C, 1'b0), 9, 50, 1'b0, 1'b1);
    wait_cycles(2);
    check("gap_key", 32'(key_out), 32'h3C);

    // Reset mid-frame, then a full frame.
    do_reset();
    drive_frame(16'h00FF, 4, 0, 1'b0, 1'b0);
    do_reset();
    drive_frame(mk(8'hA5, 1'b0), 9, 0, 1'b0, 1'b1);
    wait_cycles(2);
    check("midrst_key", 32'(key_out), 32'hA5);

    // Random frames: lengths, parity, bubbles and resets.
    for (int it = 0; it < 40; it++) begin
      if (m_valid || m_locked || $urandom_range(9) == 0) do_reset();
      len  = ($urandom_range(2) != 0) ? int'(W + 1) : int'($urandom_range(12, 1));
      bits = 16'($urandom);
      if (len == int'(W + 1) && $urandom_range(1) == 1) bits[W] = ^bits[W-1:0];
      drive_frame(bits, len, int'($urandom_range(40)), 1'b1, 1'b1);
      wait_cycles(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
